// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the register file's single write port between the ALU writeback
// (requester 0) and the load writeback (requester 1). The winner is
// registered and drives we3/a3/wd3 one cycle after the handshake.
// Also provides an in-flight write mask and a saturating conflict counter.
// Build option: define REGFILE_ARB_FIXED_PRI_EN for fixed priority
// (requester 0 always wins; no round-robin pointer). The default build
// uses round-robin.
module regfile_write_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [4:0]       req0_addr,
  input  logic [31:0]      req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [4:0]       req1_addr,
  input  logic [31:0]      req1_data,
  output logic             req1_ready,
  output logic             we3,
  output logic [4:0]       a3,
  output logic [31:0]      wd3,
  output logic             grant_id,
  output logic [31:0]      busy_mask,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic             w_grant0;
  logic             w_grant1;
  logic             w_grant;
  logic [4:0]       w_addr;
  logic [31:0]      w_data;
  logic             w_both;

  logic             r_we3;
  logic [4:0]       r_a3;
  logic [31:0]      r_wd3;
  logic             r_grant_id;
  logic [CNT_W-1:0] r_conflict_cnt;

`ifdef REGFILE_ARB_FIXED_PRI_EN
  // Fixed priority: requester 0 wins every tie, requester 1 only when alone.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (!rst) begin
      w_grant0 = req0_valid;
      w_grant1 = req1_valid && !req0_valid;
    end
  end
`else
  logic r_rr_ptr;

  // Round-robin: on a tie the requester named by r_rr_ptr wins.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (!rst) begin
      w_grant0 = req0_valid && (!req1_valid || !r_rr_ptr);
      w_grant1 = req1_valid && (!req0_valid ||  r_rr_ptr);
    end
  end

  // Pointer moves to the loser after each grant; holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= 1'b0;
    end else if (w_grant0) begin
      r_rr_ptr <= 1'b1;
    end else if (w_grant1) begin
      r_rr_ptr <= 1'b0;
    end
  end
`endif

  assign w_grant    = w_grant0 || w_grant1;
  assign w_addr     = w_grant1 ? req1_addr : req0_addr;
  assign w_data     = w_grant1 ? req1_data : req0_data;
  assign w_both     = req0_valid && req1_valid;

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  // Register the winning write; writes to x0 are accepted but not enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we3      <= 1'b0;
      r_a3       <= 5'd0;
      r_wd3      <= 32'd0;
      r_grant_id <= 1'b0;
    end else if (w_grant) begin
      r_we3      <= (w_addr != 5'd0);
      r_a3       <= w_addr;
      r_wd3      <= w_data;
      r_grant_id <= w_grant1;
    end else begin
      r_we3      <= 1'b0;
    end
  end

  // Count cycles with both requesters valid, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict_cnt <= '0;
    end else if (w_both && (r_conflict_cnt != {CNT_W{1'b1}})) begin
      r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
    end
  end

  assign we3          = r_we3;
  assign a3           = r_a3;
  assign wd3          = r_wd3;
  assign grant_id     = r_grant_id;
  assign conflict_cnt = r_conflict_cnt;
  assign busy_mask    = r_we3 ? (32'd1 << r_a3) : 32'd0;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: directed vector table plus a
// hand-written counter saturation sequence. Counter width is 4.
module tb_regfile_write_arbiter;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             req0_valid;
  logic [4:0]       req0_addr;
  logic [31:0]      req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [4:0]       req1_addr;
  logic [31:0]      req1_data;
  logic             req1_ready;
  logic             we3;
  logic [4:0]       a3;
  logic [31:0]      wd3;
  logic             grant_id;
  logic [31:0]      busy_mask;
  logic [CNT_W-1:0] conflict_cnt;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_addr    (req0_addr),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_addr    (req1_addr),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .we3          (we3),
    .a3           (a3),
    .wd3          (wd3),
    .grant_id     (grant_id),
    .busy_mask    (busy_mask),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        e_r0;
    logic        e_r1;
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    logic        e_gid;
    logic [31:0] e_mask;
    logic [3:0]  e_cnt;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v0, input logic [4:0] a0,
                       input logic [31:0] d0, input logic v1,
                       input logic [4:0] a1, input logic [31:0] d1);
    rst        = r;
    req0_valid = v0;
    req0_addr  = a0;
    req0_data  = d0;
    req1_valid = v1;
    req1_addr  = a1;
    req1_data  = d1;
  endtask

  initial begin
    // rst v0 a0 d0 v1 a1 d1 | r0 r1 we a3 wd3 gid mask cnt
    vecs[0]  = '{1,0,0,32'h0,0,0,32'h0,        0,0, 0,0,32'h0,0,32'h0,0};
    vecs[1]  = '{0,1,5,32'hDEADBEEF,0,0,32'h0, 1,0, 1,5,32'hDEADBEEF,0,32'h20,0};
    vecs[2]  = '{0,0,0,32'h0,0,0,32'h0,        0,0, 0,5,32'hDEADBEEF,0,32'h0,0};
    vecs[3]  = '{1,0,0,32'h0,0,0,32'h0,        0,0, 0,0,32'h0,0,32'h0,0};
    vecs[4]  = '{0,1,1,32'hA0,1,2,32'hB0,      1,0, 1,1,32'hA0,0,32'h2,1};
`ifdef REGFILE_ARB_FIXED_PRI_EN
    vecs[5]  = '{0,1,3,32'hA1,1,2,32'hB0,      1,0, 1,3,32'hA1,0,32'h8,2};
    vecs[6]  = '{0,1,3,32'hA1,1,4,32'hB1,      1,0, 1,3,32'hA1,0,32'h8,3};
    vecs[7]  = '{0,1,5,32'hA2,1,4,32'hB1,      1,0, 1,5,32'hA2,0,32'h20,4};
    vecs[8]  = '{0,0,0,32'h0,0,0,32'h0,        0,0, 0,5,32'hA2,0,32'h0,4};
`else
    vecs[5]  = '{0,1,3,32'hA1,1,2,32'hB0,      0,1, 1,2,32'hB0,1,32'h4,2};
    vecs[6]  = '{0,1,3,32'hA1,1,4,32'hB1,      1,0, 1,3,32'hA1,0,32'h8,3};
    vecs[7]  = '{0,1,5,32'hA2,1,4,32'hB1,      0,1, 1,4,32'hB1,1,32'h10,4};
    vecs[8]  = '{0,0,0,32'h0,0,0,32'h0,        0,0, 0,4,32'hB1,1,32'h0,4};
`endif
    vecs[9]  = '{0,0,0,32'h0,1,0,32'h12345678, 0,1, 0,0,32'h12345678,1,32'h0,4};
    vecs[10] = '{0,1,7,32'h1,1,7,32'h2,        1,0, 1,7,32'h1,0,32'h80,5};
    vecs[11] = '{0,0,0,32'h0,1,7,32'h2,        0,1, 1,7,32'h2,1,32'h80,5};
    vecs[12] = '{0,1,9,32'h99,0,0,32'h0,       1,0, 1,9,32'h99,0,32'h200,5};
    vecs[13] = '{1,1,10,32'hAA,1,11,32'hBB,    0,0, 0,0,32'h0,0,32'h0,0};
    vecs[14] = '{0,1,10,32'hAA,1,11,32'hBB,    1,0, 1,10,32'hAA,0,32'h400,1};
    vecs[15] = '{0,0,0,32'h0,1,11,32'hBB,      0,1, 1,11,32'hBB,1,32'h800,1};

    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].v0, vecs[i].a0, vecs[i].d0,
            vecs[i].v1, vecs[i].a1, vecs[i].d1);
      #1;
      check("req0_ready", i, 32'(req0_ready), 32'(vecs[i].e_r0));
      check("req1_ready", i, 32'(req1_ready), 32'(vecs[i].e_r1));
      @(posedge clk);
      #1;
      check("we3",          i, 32'(we3),          32'(vecs[i].e_we));
      check("a3",           i, 32'(a3),           32'(vecs[i].e_a3));
      check("wd3",          i, wd3,               vecs[i].e_wd);
      check("grant_id",     i, 32'(grant_id),     32'(vecs[i].e_gid));
      check("busy_mask",    i, busy_mask,         vecs[i].e_mask);
      check("conflict_cnt", i, 32'(conflict_cnt), 32'(vecs[i].e_cnt));
    end

    // Saturation: both valid for 20 cycles after a reset; count clamps at 15.
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    for (int c = 0; c < 20; c++) begin
      logic exp_gid;
      int   exp_cnt;
`ifdef REGFILE_ARB_FIXED_PRI_EN
      exp_gid = 1'b0;
`else
      exp_gid = c[0];
`endif
      exp_cnt = (c + 1 > 15) ? 15 : c + 1;
      drive(0, 1, 5'd3, 32'h100 + 32'(c), 1, 5'd6, 32'h200 + 32'(c));
      @(posedge clk);
      #1;
      check("sat_cnt",  100 + c, 32'(conflict_cnt), 32'(exp_cnt));
      check("sat_gid",  100 + c, 32'(grant_id),     32'(exp_gid));
    end

    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("sat_hold", 200, 32'(conflict_cnt), 32'd15);
    check("idle_we3", 200, 32'(we3),          32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
